// File: rtl/nop_mem_pkg.sv
// Shared types for the user-data memory controller:
// FSM state encoding and bus direction constants.
package nop_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2
  } mem_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/nop_sync2.sv
// Two-flop synchronizer, parametrised width, for
// bringing asynchronous inputs into the clk domain.
module nop_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/user_memory_ctrl.sv
// User-data RAM controller: req/ready bus, wait states,
// post-reset clear sweep and one overlaid I/O register.
module user_memory_ctrl
  import nop_mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int IO_ADDR     = 'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  localparam int IDX_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] CLR_LAST =
    IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IO_A =
    ADDR_W'(IO_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  clr_q, clr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rw_q;
  logic [DATA_W-1:0] io_sync;

  logic              cap;
  logic              fire;
  logic              hit_io;
  logic              hit_ram;
  logic [IDX_W-1:0]  ram_idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;

  nop_sync2 #(.W(DATA_W)) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (io_in),
    .q     (io_sync)
  );

  // I/O wins over RAM; no wrap of high addresses into RAM.
  assign hit_io  = (addr_q == IO_A);
  assign hit_ram = !hit_io && ({1'b0, addr_q} < DEPTH_C);
  assign ram_idx = addr_q[IDX_W-1:0];
  assign busy    = (state_q == CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CLEAR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    cap     = 1'b0;
    fire    = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = ram_idx;
    mem_wd  = wdata_q;
    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_q;
        mem_wd = '0;
        clr_d  = clr_q + 1'b1;
        if (clr_q == CLR_LAST) state_d = IDLE;
      end
      IDLE: begin
        if (req) begin
          cap     = 1'b1;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          fire    = 1'b1;
          mem_we  = (rw_q == RW_WRITE) && hit_ram;
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      clr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= RW_READ;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      io_out  <= '0;
    end else begin
      cnt_q <= cnt_d;
      clr_q <= clr_d;
      ready <= fire;
      err   <= fire && !hit_io && !hit_ram;
      if (cap) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        rw_q    <= rw;
      end
      if (fire && rw_q == RW_READ) begin
        unique case (1'b1)
          hit_io:  rdata <= io_sync;
          hit_ram: rdata <= mem[ram_idx];
          default: rdata <= '0;
        endcase
      end
      if (fire && rw_q == RW_WRITE && hit_io)
        io_out <= wdata_q;
    end
  end

  // Single write port shared by the sweep and bus writes.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_user_memory_ctrl.sv
// Self-checking bench: two controller configurations
// driven with directed and random traffic vs. a model.
module tb_user_memory_ctrl;

  logic       clk;
  logic       reset_n;
  logic       req    [2];
  logic       rw     [2];
  logic [7:0] addr   [2];
  logic [7:0] wdata  [2];
  logic [7:0] rdata  [2];
  logic       ready  [2];
  logic       err    [2];
  logic       busy   [2];
  logic [7:0] io_in  [2];
  logic [7:0] io_out [2];

  int n_tests = 0;
  int n_fail  = 0;

  int         depth [2] = '{256, 16};
  int         ws    [2] = '{0, 3};
  logic [7:0] mdl   [2][256];
  logic [7:0] m_io  [2];
  logic [7:0] m_rd  [2];

  user_memory_ctrl #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(256),
    .WAIT_STATES(0), .IO_ADDR('hFF)
  ) u0 (
    .clk(clk), .reset_n(reset_n),
    .req(req[0]), .rw(rw[0]),
    .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ready(ready[0]),
    .err(err[0]), .busy(busy[0]),
    .io_in(io_in[0]), .io_out(io_out[0])
  );

  user_memory_ctrl #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(16),
    .WAIT_STATES(3), .IO_ADDR('hFF)
  ) u1 (
    .clk(clk), .reset_n(reset_n),
    .req(req[1]), .rw(rw[1]),
    .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ready(ready[1]),
    .err(err[1]), .busy(busy[1]),
    .io_in(io_in[1]), .io_out(io_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a++) mdl[d][a] = 8'h00;
      m_io[d] = 8'h00;
      m_rd[d] = 8'h00;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((busy[0] || busy[1]) && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    if (busy[0] || busy[1]) chk("idle_timeout", 1, 0);
  endtask

  task automatic access(input int d, input logic w,
                        input logic [7:0] a,
                        input logic [7:0] wd,
                        input bit wiggle);
    int   lat;
    bit   got;
    logic exp_err;
    @(posedge clk); #1;
    req[d] = 1'b1; rw[d] = w;
    addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    req[d] = 1'b0;
    addr[d] = 8'($urandom);
    wdata[d] = 8'($urandom);
    lat = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready[d]) begin
        got = 1;
        break;
      end
      if (wiggle) req[d] = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    req[d] = 1'b0;
    chk("ready_seen", 32'(got), 1);
    if (got) begin
      exp_err = (a != 8'hFF) && (int'(a) >= depth[d]);
      if (w) begin
        if (a == 8'hFF) m_io[d] = wd;
        else if (int'(a) < depth[d]) mdl[d][a] = wd;
      end else begin
        if (a == 8'hFF) m_rd[d] = io_in[d];
        else if (int'(a) < depth[d]) m_rd[d] = mdl[d][a];
        else m_rd[d] = 8'h00;
      end
      chk("latency", 32'(lat), 32'(ws[d] + 1));
      chk("err", 32'(err[d]), 32'(exp_err));
      chk("rdata", 32'(rdata[d]), 32'(m_rd[d]));
      chk("io_out", 32'(io_out[d]), 32'(m_io[d]));
      @(posedge clk); #1;
      chk("ready_pulse", 32'(ready[d]), 0);
    end
  endtask

  task automatic set_io(input int d, input logic [7:0] v);
    io_in[d] = v;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int  c;
    int  fall [2];
    bit  rdy_busy;
    int  d;
    int  r;
    logic [7:0] a;

    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; rw[i] = 0; addr[i] = 0;
      wdata[i] = 0; io_in[i] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rdata", 32'(rdata[i]), 0);
      chk("rst_ready", 32'(ready[i]), 0);
      chk("rst_err", 32'(err[i]), 0);
      chk("rst_busy", 32'(busy[i]), 1);
      chk("rst_io_out", 32'(io_out[i]), 0);
    end

    // Sweep length, with a request held that must be ignored.
    @(negedge clk);
    reset_n = 1'b1;
    req[0] = 1'b1; rw[0] = 1'b1;
    addr[0] = 8'h10; wdata[0] = 8'h77;
    fall[0] = 0; fall[1] = 0;
    rdy_busy = 0;
    c = 0;
    while ((fall[0] == 0 || fall[1] == 0) && c < 400) begin
      @(posedge clk); #1;
      c++;
      if (c == 5) req[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (ready[i]) rdy_busy = 1;
        if (fall[i] == 0 && !busy[i]) fall[i] = c;
      end
    end
    chk("busy_len0", 32'(fall[0]), 256);
    chk("busy_len1", 32'(fall[1]), 16);
    chk("ready_in_clear", 32'(rdy_busy), 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 255; i++)
      access(0, 1'b0, 8'(i), 8'h00, 0);
    for (int i = 0; i < 16; i++)
      access(1, 1'b0, 8'(i), 8'h00, 1);

    access(0, 1'b1, 8'h10, 8'hDE, 0);
    access(0, 1'b0, 8'h10, 8'h00, 0);
    chk("rd_DE", 32'(rdata[0]), 32'h00DE);

    access(1, 1'b0, 8'h03, 8'h00, 1);

    access(0, 1'b1, 8'hFF, 8'h33, 0);
    chk("io_33", 32'(io_out[0]), 32'h33);
    set_io(0, 8'hAA);
    access(0, 1'b0, 8'hFF, 8'h00, 0);
    chk("io_AA", 32'(rdata[0]), 32'hAA);

    access(1, 1'b1, 8'h00, 8'h5C, 1);
    access(1, 1'b0, 8'h20, 8'h00, 1);
    access(1, 1'b1, 8'h20, 8'h99, 1);
    access(1, 1'b0, 8'h00, 8'h00, 1);
    chk("oob_nowrap", 32'(rdata[1]), 32'h5C);

    for (int i = 0; i < 160; i++) begin
      d = int'($urandom_range(1, 0));
      r = int'($urandom_range(3, 0));
      case (r)
        0: a = 8'hFF;
        1: a = 8'($urandom_range(depth[d] - 1, 0));
        2: a = 8'($urandom);
        default: a = 8'($urandom_range(40, 16));
      endcase
      if ($urandom_range(7, 0) == 0)
        set_io(d, 8'($urandom));
      access(d, 1'($urandom), a, 8'($urandom), d == 1);
    end

    // Reset in the middle of a wait-stated write.
    @(posedge clk); #1;
    req[1] = 1'b1; rw[1] = 1'b1;
    addr[1] = 8'h05; wdata[1] = 8'h55;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("abort_ready", 32'(ready[1]), 0);
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy[1]), 1);
    reset_n = 1'b1;
    rdy_busy = 0;
    c = 0;
    while (busy[1] && c < 40) begin
      if (ready[1]) rdy_busy = 1;
      @(posedge clk); #1;
      c++;
    end
    chk("abort_no_ready", 32'(rdy_busy), 0);
    wait_idle();
    access(1, 1'b0, 8'h05, 8'h00, 0);
    chk("abort_rd05", 32'(rdata[1]), 0);
    access(0, 1'b0, 8'h10, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
